// File: rtl/triangle_phase_decoder.sv
// triangle_phase_decoder: recovers the phase counter behind a triangle sample stream and flags lock and slope errors.
// Optional saturating error counter port err_count is built when TRI_DEC_ERRCNT_EN is defined.
module triangle_phase_decoder #(
  parameter int LOCK_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  output logic [7:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic       slope_err
`ifdef TRI_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  typedef enum logic {HUNT, LOCKED} state_e;
  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
  function automatic logic [7:0] tri_f(input logic [7:0] c);
    return c[7] ? 8'd255 - c : c;
  endfunction
  function automatic logic [7:0] pred_f(input logic [7:0] x);
    return tri_f(x + 8'd1);
  endfunction
  state_e     state_q, state_d;
  logic       have_prev_q, have_prev_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] phase_q, phase_d;
  logic       phase_valid_q, phase_valid_d;
  logic       locked_q, locked_d;
  logic       slope_err_q, slope_err_d;
  logic       rule_hit;
  logic [7:0] rule_cand;
  // Seed a candidate from two consecutive samples; samples above 127 never qualify.
  always_comb begin
    rule_hit  = 1'b0;
    rule_cand = 8'd0;
    if (have_prev_q && !sample[7]) begin
      if (sample == prev_q && sample == 8'd127) begin
        rule_hit  = 1'b1;
        rule_cand = 8'd128;
      end else if (sample == prev_q && sample == 8'd0) begin
        rule_hit  = 1'b1;
        rule_cand = 8'd0;
      end else if ({1'b0, sample} == {1'b0, prev_q} + 9'd1) begin
        rule_hit  = 1'b1;
        rule_cand = sample;
      end else if (prev_q != 8'd0 && sample == prev_q - 8'd1) begin
        rule_hit  = 1'b1;
        rule_cand = 8'd255 - sample;
      end
    end
  end
  always_comb begin
    state_d       = state_q;
    have_prev_d   = have_prev_q;
    match_cnt_d   = match_cnt_q;
    prev_d        = prev_q;
    cand_d        = cand_q;
    phase_d       = phase_q;
    locked_d      = locked_q;
    phase_valid_d = 1'b0;
    slope_err_d   = 1'b0;
    if (sample_valid) begin
      if (state_q == HUNT) begin
        if (have_prev_q && match_cnt_q != 4'd0 && sample == pred_f(cand_q)) begin
          cand_d      = cand_q + 8'd1;
          match_cnt_d = match_cnt_q + 4'd1;
        end else begin
          cand_d      = rule_hit ? rule_cand : cand_q;
          match_cnt_d = rule_hit ? 4'd1 : 4'd0;
        end
        prev_d      = sample;
        have_prev_d = 1'b1;
        if (match_cnt_d == LOCK_N) begin
          state_d       = LOCKED;
          phase_d       = cand_d;
          locked_d      = 1'b1;
          phase_valid_d = 1'b1;
        end
      end else if (sample == pred_f(phase_q)) begin
        phase_d       = phase_q + 8'd1;
        phase_valid_d = 1'b1;
      end else begin
        slope_err_d = 1'b1;
        locked_d    = 1'b0;
        state_d     = HUNT;
        match_cnt_d = 4'd0;
        prev_d      = sample;
        have_prev_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      have_prev_q   <= 1'b0;
      match_cnt_q   <= 4'd0;
      prev_q        <= 8'd0;
      cand_q        <= 8'd0;
      phase_q       <= 8'd0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      slope_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      have_prev_q   <= have_prev_d;
      match_cnt_q   <= match_cnt_d;
      prev_q        <= prev_d;
      cand_q        <= cand_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      slope_err_q   <= slope_err_d;
    end
  end
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign slope_err   = slope_err_q;
`ifdef TRI_DEC_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  assign err_count_d = (slope_err_d && err_count_q != 8'd255) ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_count_q <= 8'd0;
    else      err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_triangle_phase_decoder.sv
// tb_triangle_phase_decoder: directed-vector bench for triangle_phase_decoder with LOCK_LEN = 4.
module tb_triangle_phase_decoder;
  logic       clk, rst, sample_valid;
  logic [7:0] sample, phase;
  logic       phase_valid, locked, slope_err;
  int         n_checks = 0;
  int         n_fail = 0;
`ifdef TRI_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif
  triangle_phase_decoder #(.LOCK_LEN(4)) dut (
    .clk(clk),
    .rst(rst),
    .sample_valid(sample_valid),
    .sample(sample),
    .phase(phase),
    .phase_valid(phase_valid),
    .locked(locked),
    .slope_err(slope_err)
`ifdef TRI_DEC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] tri_f(input int c);
    int m;
    m = c % 256;
    return (m < 128) ? 8'(m) : 8'(255 - m);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [7:0] s, input logic v);
    @(negedge clk);
    sample = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic check_clean(input int c);
    check("lock_locked", 32'(locked), 32'(c >= 4));
    check("lock_pv", 32'(phase_valid), 32'(c >= 4));
    check("lock_phase", 32'(phase), (c >= 4) ? 32'(c % 256) : 32'd0);
    check("lock_serr", 32'(slope_err), 32'd0);
  endtask
  initial begin
    logic [7:0] plat_in [8];
    logic [7:0] plat_exp [8];
    logic [7:0] held;
    logic       held_lock;
    plat_in  = '{8'd126, 8'd127, 8'd127, 8'd126, 8'd1, 8'd0, 8'd0, 8'd1};
    plat_exp = '{8'd126, 8'd127, 8'd128, 8'd129, 8'd254, 8'd255, 8'd0, 8'd1};
    rst = 1'b0;
    sample_valid = 1'b0;
    sample = 8'd0;
    #12;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_pv", 32'(phase_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_serr", 32'(slope_err), 32'd0);
`ifdef TRI_DEC_ERRCNT_EN
    check("rst_errcnt", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 512; c++) begin
      step(tri_f(c), 1'b1);
      check_clean(c);
    end
    for (int c = 512; c < 638; c++) step(tri_f(c), 1'b1);
    check("pre_plat_phase", 32'(phase), 32'd125);
    for (int i = 0; i < 4; i++) begin
      step(plat_in[i], 1'b1);
      check("plat_top", 32'(phase), 32'(plat_exp[i]));
    end
    for (int c = 130; c < 254; c++) step(tri_f(c), 1'b1);
    check("pre_bot_phase", 32'(phase), 32'd253);
    for (int i = 4; i < 8; i++) begin
      step(plat_in[i], 1'b1);
      check("plat_bot", 32'(phase), 32'(plat_exp[i]));
      check("plat_serr", 32'(slope_err), 32'd0);
    end
    for (int c = 2; c < 41; c++) step(tri_f(c), 1'b1);
    check("pre_glitch_phase", 32'(phase), 32'd40);
    step(8'd50, 1'b1);
    check("glitch_serr", 32'(slope_err), 32'd1);
    check("glitch_locked", 32'(locked), 32'd0);
    check("glitch_phase", 32'(phase), 32'd40);
    check("glitch_pv", 32'(phase_valid), 32'd0);
    step(8'd51, 1'b1);
    check("glitch_serr_pulse", 32'(slope_err), 32'd0);
    for (int s = 52; s < 54; s++) begin
      step(8'(s), 1'b1);
      check("relock_wait", 32'(locked), 32'd0);
    end
    step(8'd54, 1'b1);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_phase", 32'(phase), 32'd54);
    check("relock_pv", 32'(phase_valid), 32'd1);
    do_reset();
    for (int c = 0; c < 512; c++) begin
      step(tri_f(c), 1'b1);
      check_clean(c);
      held = phase;
      held_lock = locked;
      step(8'hAA, 1'b0);
      check("gap_pv", 32'(phase_valid), 32'd0);
      check("gap_serr", 32'(slope_err), 32'd0);
      check("gap_phase", 32'(phase), 32'(held));
      check("gap_locked", 32'(locked), 32'(held_lock));
    end
    do_reset();
    for (int c = 0; c <= 200; c++) step(tri_f(c), 1'b1);
    check("pre_arst_phase", 32'(phase), 32'd200);
    check("pre_arst_locked", 32'(locked), 32'd1);
    rst = 1'b0;
    #1;
    check("arst_phase", 32'(phase), 32'd0);
    check("arst_pv", 32'(phase_valid), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_serr", 32'(slope_err), 32'd0);
    #1;
    rst = 1'b1;
    for (int c = 10; c < 14; c++) begin
      step(tri_f(c), 1'b1);
      check("arst_relock_wait", 32'(locked), 32'd0);
    end
    step(tri_f(14), 1'b1);
    check("arst_relock", 32'(locked), 32'd1);
    check("arst_relock_phase", 32'(phase), 32'd14);
`ifdef TRI_DEC_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      step(8'd120, 1'b1);
      if (i == 0) check("errcnt_first", 32'(err_count), 32'd1);
      for (int s = 121; s < 125; s++) step(8'(s), 1'b1);
    end
    check("errcnt_sat", 32'(err_count), 32'd255);
    check("errcnt_relock", 32'(locked), 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/triangle_phase_decoder.md
# triangle_phase_decoder

Inverse of the lab's triangle waveform generator. It consumes the 8-bit triangle sample stream, with T(c) = c for c < 128 and T(c) = 255 − c for c ≥ 128. It reconstructs the 8-bit phase counter c that produced each sample and reports lock and slope errors. It sits on the loopback/check path after the waveform generator so the bench and board can confirm the generated waveform is a clean triangle.

## Interface
Parameters:
- LOCK_LEN, default 4: consecutive correctly predicted samples required before lock; legal range 1..15.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- sample_valid, input, 1: sample qualifier; the block advances only when this is 1.
- sample, input, 8: triangle sample, range 0..127.
- phase, output, 8: reconstructed counter value for the last accepted sample.
- phase_valid, output, 1: one-cycle pulse; phase is valid and locked.
- locked, output, 1: level; the decoder is tracking.
- slope_err, output, 1: one-cycle pulse; a locked prediction was missed.
- err_count, output, 8: saturating count of slope_err pulses. Present only with TRI_DEC_ERRCNT_EN.

## Operation
- Reset values (applied asynchronously while rst = 0):
  - Outputs: phase = 0, phase_valid = 0, locked = 0, slope_err = 0, err_count = 0.
  - Internal: state = HUNT, have_prev = 0, match_cnt = 0, prev = 0, cand = 0.
- When sample_valid = 0: all state holds and phase_valid and slope_err drive 0.
- Prediction function: E(x) = T((x + 1) mod 256), computed in 8-bit arithmetic with wrap-around from 255 to 0.
- State HUNT, on each valid sample s:
  - If have_prev = 1, match_cnt > 0, and s = E(cand): set cand ← cand + 1 and match_cnt ← match_cnt + 1.
  - Otherwise, derive cand from the pair (prev, s) and set match_cnt ← 1 if a rule applies, else 0. Rules, in priority order:
    - s = prev = 127 → cand = 128.
    - s = prev = 0 → cand = 0.
    - s = prev + 1 and s ≤ 127 → cand = s.
    - s = prev − 1 and prev ≥ 1 → cand = 255 − s.
    - Anything else → no candidate.
  - Always set prev ← s and have_prev ← 1.
  - When match_cnt reaches LOCK_LEN in this update: go to LOCKED, set phase ← new cand, locked ← 1, and pulse phase_valid = 1.
- State LOCKED, on each valid sample s:
  - If s = E(phase): set phase ← phase + 1 and pulse phase_valid = 1.
  - Otherwise:
    - Pulse slope_err = 1 and set locked ← 0.
    - Go to HUNT with match_cnt ← 0, prev ← s, have_prev ← 1.
    - phase holds its last value; phase_valid = 0.
- Plateau samples (127,127 and 0,0) are legal and advance phase 127→128 and 255→0 respectively.
- Samples greater than 127 never match any prediction or rule.
  - In LOCKED they cause slope_err.
  - In HUNT they reset match_cnt to 0.

## Timing
- Latency: phase, phase_valid and slope_err update on the same clk edge that samples sample_valid = 1, and are visible for the following cycle.
- Lock latency from reset on a clean stream: LOCK_LEN + 1 valid samples (the first sample only seeds prev).
- Lock loss is immediate on the first miss; there is no hysteresis.
- Re-lock after a miss: the missed sample seeds prev, so LOCK_LEN further clean samples are needed.
- Back-to-back valid samples every cycle are supported; gaps of any length are tolerated with no timeout.
- An rst assertion mid-stream clears everything within the same cycle (asynchronous); after release the block restarts in HUNT with have_prev = 0.

## Configuration
- Macro TRI_DEC_ERRCNT_EN.
- Defined:
  - The err_count port and register exist.
  - err_count increments on every slope_err pulse and saturates at 255; only rst clears it.
- Undefined:
  - The err_count port and register are absent.
  - All other behaviour is identical.

## Test plan
- Clean lock: drive T(c) for c = 0..511 on consecutive cycles, LOCK_LEN = 4. Required: locked rises after sample c = 4 with phase = 4, then phase = c on every subsequent cycle, wrapping 255→0, with slope_err never asserted.
- Plateaus: after lock, feed 126, 127, 127, 126. Required: phase reads 126, 127, 128, 129. Feed 1, 0, 0, 1. Required: phase reads 254, 255, 0, 1.
- Glitch: after lock at phase 40, feed 50 instead of 41. Required: slope_err pulses for one cycle, locked = 0, phase holds 40. Then feed 51, 52, 53, 54. Required: re-lock with phase = 54.
- Gappy stream: clean stream with sample_valid toggling 1/0 on alternate cycles. Required: identical phase sequence to the first scenario; phase_valid is asserted only in cycles following a valid sample.
- Async reset mid-operation: assert rst while locked at phase 200. Required: all outputs are 0 before the next clk edge; after release, re-lock takes LOCK_LEN + 1 samples.
- Error counter (macro defined): inject 300 isolated glitches. Required: err_count = 255, saturated. With the macro undefined: build compiles with no err_count port.
